// File: rtl/cg_seq_pkg.sv
// rtl/cg_seq_pkg.sv - shared state type, phase-level encodings and default widths for the CG sequencer
package cg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        ARM      = 3'd2,
        RUN      = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } seq_state_e;

    // The two phase controls have opposite polarity on the core.
    localparam logic MXV_RUN  = 1'b1;
    localparam logic MXV_HOLD = 1'b0;
    localparam logic VXV_RUN  = 1'b0;
    localparam logic VXV_HOLD = 1'b1;

    localparam int DEF_ITER_W = 16;
    localparam int TMR_W      = 16;

endpackage

// File: rtl/cg_phase_sequencer_if.sv
// rtl/cg_phase_sequencer_if.sv - run-control signals between the sequencer (master) and core/host side (slave)
interface cg_phase_sequencer_if #(
    parameter int ITER_W = cg_seq_pkg::DEF_ITER_W
);
    logic              start;
    logic              finish;
    logic              halt;
    logic              core_reset;
    logic              reset_mXv1;
    logic              reset_vXv1;
    logic [ITER_W-1:0] iter_count;
    logic              busy;
    logic              done;
    logic              timeout;

    modport master (
        input  start, finish, halt,
        output core_reset, reset_mXv1, reset_vXv1, iter_count, busy, done, timeout
    );

    modport slave (
        output start, finish, halt,
        input  core_reset, reset_mXv1, reset_vXv1, iter_count, busy, done, timeout
    );
endinterface

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable saturating down-counter with zero flag
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/cg_phase_sequencer.sv
// rtl/cg_phase_sequencer.sv - CG core run controller: reset, phase re-arm, iteration count, halt
// CG_SEQ_TIMEOUT_EN builds the RUN watchdog; otherwise timeout is tied low.
module cg_phase_sequencer
    import cg_seq_pkg::*;
#(
    parameter int CORE_RST_CYCLES = 2,
    parameter int GAP_CYCLES      = 5,
    parameter int MAX_ITER        = 256,
    parameter int ITER_W          = DEF_ITER_W,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input logic                  clk,
    input logic                  reset,
    cg_phase_sequencer_if.master bus
);
    seq_state_e        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              core_reset_q, core_reset_d;
    logic              mxv_q, mxv_d;
    logic              vxv_q, vxv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              finish_prev_q, finish_prev_d;
    logic              fin_edge, last_iter;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_load_val;

    // Sampling finish every cycle means a level still high on RUN entry never looks like an edge.
    assign finish_prev_d = bus.finish;
    assign fin_edge      = bus.finish && !finish_prev_q;
    assign last_iter     = (iter_q == ITER_W'(MAX_ITER - 1));

    assign tmr_load     = (state_d != state_q) && ((state_d == CORE_RST) || (state_d == GAP));
    assign tmr_load_val = (state_d == CORE_RST) ? TMR_W'(CORE_RST_CYCLES - 1) : TMR_W'(GAP_CYCLES - 1);

    seq_down_counter #(.W(TMR_W)) u_interval (
        .clk      (clk),
        .rst_n    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (1'b1),
        .zero     (tmr_zero)
    );

`ifdef CG_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic timeout_q, timeout_d;
    logic wd_zero, wd_fire;

    seq_down_counter #(.W(WD_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (reset),
        .load     ((state_d == RUN) && (state_q != RUN)),
        .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .en       (state_q == RUN),
        .zero     (wd_zero)
    );

    assign wd_fire     = (state_q == RUN) && wd_zero;
    assign bus.timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign bus.timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
`ifdef CG_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = CORE_RST;
                    iter_d  = '0;
`ifdef CG_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            CORE_RST: begin
                if (bus.halt)      state_d = DONE;
                else if (tmr_zero) state_d = ARM;
            end
            ARM: state_d = bus.halt ? DONE : RUN;
            RUN: begin
                // The edge is counted even when halt or the watchdog wins the transition.
                if (fin_edge) iter_d = iter_q + ITER_W'(1);
                if (bus.halt) begin
                    state_d = DONE;
                end
`ifdef CG_SEQ_TIMEOUT_EN
                else if (wd_fire) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
`endif
                else if (fin_edge) begin
                    state_d = last_iter ? DONE : GAP;
                end
            end
            GAP: begin
                if (bus.halt)      state_d = DONE;
                else if (tmr_zero) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies track state_q exactly.
    always_comb begin
        core_reset_d = 1'b0;
        mxv_d        = MXV_HOLD;
        vxv_d        = VXV_HOLD;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            IDLE:     core_reset_d = 1'b1;
            CORE_RST: begin
                core_reset_d = 1'b1;
                busy_d       = 1'b1;
            end
            ARM, GAP: busy_d = 1'b1;
            RUN: begin
                busy_d = 1'b1;
                mxv_d  = MXV_RUN;
                vxv_d  = VXV_RUN;
            end
            DONE:     done_d = 1'b1;
            default:  core_reset_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            iter_q        <= '0;
            core_reset_q  <= 1'b1;
            mxv_q         <= MXV_HOLD;
            vxv_q         <= VXV_HOLD;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            finish_prev_q <= 1'b0;
`ifdef CG_SEQ_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            core_reset_q  <= core_reset_d;
            mxv_q         <= mxv_d;
            vxv_q         <= vxv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            finish_prev_q <= finish_prev_d;
`ifdef CG_SEQ_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.reset_mXv1 = mxv_q;
    assign bus.reset_vXv1 = vxv_q;
    assign bus.iter_count = iter_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_cg_phase_sequencer.sv
// tb/tb_cg_phase_sequencer.sv - directed self-checking bench for cg_phase_sequencer (MAX_ITER=3)
module tb_cg_phase_sequencer;
    // {core_reset, reset_mXv1, reset_vXv1, busy, done, timeout}
    localparam logic [5:0] O_IDLE = 6'b101000;
    localparam logic [5:0] O_CRST = 6'b101100;
    localparam logic [5:0] O_ARM  = 6'b001100;
    localparam logic [5:0] O_RUN  = 6'b010100;
    localparam logic [5:0] O_GAP  = 6'b001100;
    localparam logic [5:0] O_DONE = 6'b001010;
    localparam logic [5:0] O_TOUT = 6'b001011;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cg_phase_sequencer_if #(.ITER_W(16)) bus ();

    cg_phase_sequencer #(
        .CORE_RST_CYCLES (2),
        .GAP_CYCLES      (5),
        .MAX_ITER        (3),
        .ITER_W          (16),
        .TIMEOUT_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.core_reset, bus.reset_mXv1, bus.reset_vXv1, bus.busy, bus.done, bus.timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.finish = 1'b0;
        bus.halt = 1'b0;
        repeat (3) tick();
        checks++; if (outs() !== O_IDLE) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs(), O_IDLE); end
        checks++; if (bus.iter_count !== 16'd0) begin failures++; $display("FAIL reset_iter got=%0d exp=0", bus.iter_count); end
        #3 reset = 1'b1;
        bus.halt = 1'b1;
        repeat (2) tick();
        bus.halt = 1'b0;
        checks++; if (outs() !== O_IDLE) begin failures++; $display("FAIL idle_hold got=%b exp=%b", outs(), O_IDLE); end
    endtask

    task automatic test_start();
        pulse_start();
        checks++; if (outs() !== O_CRST) begin failures++; $display("FAIL start_crst1 got=%b exp=%b", outs(), O_CRST); end
        tick();
        checks++; if (outs() !== O_CRST) begin failures++; $display("FAIL start_crst2 got=%b exp=%b", outs(), O_CRST); end
        tick();
        checks++; if (outs() !== O_ARM) begin failures++; $display("FAIL start_arm got=%b exp=%b", outs(), O_ARM); end
        tick();
        checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL start_run got=%b exp=%b", outs(), O_RUN); end
        checks++; if (bus.iter_count !== 16'd0) begin failures++; $display("FAIL start_iter got=%0d exp=0", bus.iter_count); end
    endtask

    task automatic test_iterations();
        for (int p = 1; p <= 3; p++) begin
            repeat (2) tick();
            bus.finish = 1'b1;
            tick();
            bus.finish = 1'b0;
            checks++; if (bus.iter_count !== 16'(p)) begin failures++; $display("FAIL iter_pulse%0d got=%0d exp=%0d", p, bus.iter_count, p); end
            if (p < 3) begin
                checks++; if (outs() !== O_GAP) begin failures++; $display("FAIL gap%0d_c1 got=%b exp=%b", p, outs(), O_GAP); end
                for (int c = 2; c <= 5; c++) begin
                    tick();
                    checks++; if (outs() !== O_GAP) begin failures++; $display("FAIL gap%0d_c%0d got=%b exp=%b", p, c, outs(), O_GAP); end
                end
                tick();
                checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL gap%0d_exit got=%b exp=%b", p, outs(), O_RUN); end
            end else begin
                checks++; if (outs() !== O_DONE) begin failures++; $display("FAIL max_iter_done got=%b exp=%b", outs(), O_DONE); end
            end
        end
        tick();
        checks++; if (outs() !== O_DONE || bus.iter_count !== 16'd3) begin failures++; $display("FAIL done_hold got=%b/%0d exp=%b/3", outs(), bus.iter_count, O_DONE); end
    endtask

    task automatic test_finish_level();
        pulse_start();
        checks++; if (bus.iter_count !== 16'd0) begin failures++; $display("FAIL restart_iter got=%0d exp=0", bus.iter_count); end
        repeat (3) tick();
        bus.finish = 1'b1;
        tick();
        checks++; if (outs() !== O_GAP || bus.iter_count !== 16'd1) begin failures++; $display("FAIL level_gap got=%b/%0d exp=%b/1", outs(), bus.iter_count, O_GAP); end
        repeat (5) tick();
        checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL level_run got=%b exp=%b", outs(), O_RUN); end
        repeat (3) tick();
        bus.finish = 1'b0;
        tick();
        checks++; if (outs() !== O_RUN || bus.iter_count !== 16'd1) begin failures++; $display("FAIL level_nocount got=%b/%0d exp=%b/1", outs(), bus.iter_count, O_RUN); end
    endtask

    task automatic test_halt_gap();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        tick();
        checks++; if (outs() !== O_GAP || bus.iter_count !== 16'd2) begin failures++; $display("FAIL halt_pre got=%b/%0d exp=%b/2", outs(), bus.iter_count, O_GAP); end
        bus.halt = 1'b1;
        tick();
        checks++; if (outs() !== O_DONE || bus.iter_count !== 16'd2) begin failures++; $display("FAIL halt_gap got=%b/%0d exp=%b/2", outs(), bus.iter_count, O_DONE); end
        repeat (2) tick();
        bus.halt = 1'b0;
        checks++; if (outs() !== O_DONE) begin failures++; $display("FAIL halt_in_done got=%b exp=%b", outs(), O_DONE); end
        pulse_start();
        checks++; if (outs() !== O_CRST || bus.iter_count !== 16'd0) begin failures++; $display("FAIL halt_restart got=%b/%0d exp=%b/0", outs(), bus.iter_count, O_CRST); end
    endtask

    task automatic test_halt_edge();
        repeat (3) tick();
        bus.finish = 1'b1;
        bus.halt = 1'b1;
        tick();
        bus.finish = 1'b0;
        bus.halt = 1'b0;
        checks++; if (outs() !== O_DONE || bus.iter_count !== 16'd1) begin failures++; $display("FAIL halt_edge got=%b/%0d exp=%b/1", outs(), bus.iter_count, O_DONE); end
        pulse_start();
        tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        checks++; if (outs() !== O_DONE) begin failures++; $display("FAIL halt_crst got=%b exp=%b", outs(), O_DONE); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        repeat (3) tick();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        repeat (5) tick();
        checks++; if (outs() !== O_RUN || bus.iter_count !== 16'd1) begin failures++; $display("FAIL pre_reset got=%b/%0d exp=%b/1", outs(), bus.iter_count, O_RUN); end
        #2 reset = 1'b0;
        #1;
        checks++; if (outs() !== O_IDLE || bus.iter_count !== 16'd0) begin failures++; $display("FAIL async_reset got=%b/%0d exp=%b/0", outs(), bus.iter_count, O_IDLE); end
        #2 reset = 1'b1;
        repeat (3) tick();
        checks++; if (outs() !== O_IDLE) begin failures++; $display("FAIL reset_needs_start got=%b exp=%b", outs(), O_IDLE); end
        pulse_start();
        checks++; if (outs() !== O_CRST) begin failures++; $display("FAIL reset_resume got=%b exp=%b", outs(), O_CRST); end
    endtask

`ifdef CG_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        pulse_start();
        repeat (3) tick();
        for (int c = 2; c <= 10; c++) begin
            tick();
            checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL wd_run_c%0d got=%b exp=%b", c, outs(), O_RUN); end
        end
        tick();
        checks++; if (outs() !== O_TOUT) begin failures++; $display("FAIL wd_fire got=%b exp=%b", outs(), O_TOUT); end
        pulse_start();
        checks++; if (outs() !== O_CRST) begin failures++; $display("FAIL wd_clear got=%b exp=%b", outs(), O_CRST); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_start();
        test_iterations();
        test_finish_level();
        test_halt_gap();
        test_halt_edge();
        test_reset_mid_run();
`ifdef CG_SEQ_TIMEOUT_EN
        test_timeout();
`else
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL timeout_tied got=%b exp=0", bus.timeout); end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
